// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Byte-lane data memory serving one load/store per valid/ready
//            handshake, with load extension and misalignment reporting.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  MemWrite,
    input  logic [2:0]  LdType,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] rdata,
    output logic        resp_err
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_READ = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    localparam logic [1:0] c_MW_LOAD = 2'b00;
    localparam logic [1:0] c_MW_SW   = 2'b01;
    localparam logic [1:0] c_MW_SH   = 2'b10;

    localparam logic [2:0] c_LD_LH  = 3'b001;
    localparam logic [2:0] c_LD_LHU = 3'b010;
    localparam logic [2:0] c_LD_LB  = 3'b011;
    localparam logic [2:0] c_LD_LBU = 3'b100;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [31:0]       r_mem [DEPTH];
    logic [1:0]        r_lo;
    logic [2:0]        r_ld;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_is_load;
    logic              w_word_acc;
    logic              w_half_acc;
    logic              w_misal;
    logic              w_wr_en;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;
    logic              w_unused;

    // Upper address bits are dropped so the memory aliases modulo DEPTH*4.
    assign w_idx    = addr[ADDR_W+1:2];
    assign w_unused = &{1'b0, addr[31:ADDR_W+2]};

    assign w_accept   = req_valid & (r_state == c_S_IDLE);
    assign w_is_load  = (MemWrite == c_MW_LOAD);
    assign w_half_acc = (MemWrite == c_MW_SH) |
                        (w_is_load & ((LdType == c_LD_LH) | (LdType == c_LD_LHU)));
    assign w_word_acc = (MemWrite == c_MW_SW) |
                        (w_is_load & (LdType != c_LD_LH) & (LdType != c_LD_LHU) &
                         (LdType != c_LD_LB) & (LdType != c_LD_LBU));
    assign w_misal    = (w_word_acc & (addr[1:0] != 2'b00)) | (w_half_acc & addr[0]);
    assign w_wr_en    = w_accept & ~w_is_load & ~w_misal;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata;
        case (MemWrite)
            c_MW_SW: w_be = 4'b1111;
            c_MW_SH: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {wdata[15:0], wdata[15:0]};
            end
            2'b11: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[r_idx];
    assign w_byte    = w_rd_word[8*r_lo +: 8];
    assign w_half    = r_lo[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        case (r_ld)
            c_LD_LH:  w_ext = {{16{w_half[15]}}, w_half};
            c_LD_LHU: w_ext = {16'h0000, w_half};
            c_LD_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_ext = {24'h000000, w_byte};
            default:  w_ext = w_rd_word;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_is_load & ~w_misal) ? c_S_READ : c_S_RESP;
                end
            end
            c_S_READ: w_next_state = c_S_RESP;
            c_S_RESP: begin
                if (resp_ready) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // Request fields and response payload
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo    <= '0;
            r_ld    <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_lo    <= addr[1:0];
                        r_ld    <= LdType;
                        r_idx   <= w_idx;
                        r_rdata <= '0;
                        r_err   <= w_misal;
                    end
                end
                c_S_READ: r_rdata <= w_ext;
                c_S_RESP: begin
                    if (resp_ready) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        req_ready  = (r_state == c_S_IDLE);
        resp_valid = (r_state == c_S_RESP);
        rdata      = r_rdata;
        resp_err   = r_err;
    end

endmodule
`default_nettype wire
